// File: rtl/rotary_ctrl_pkg.sv
// Shared constants for the rotary encoder event controller: register map,
// STATUS bit layout and the CPU/preset sequencer state encoding.
package rotary_ctrl_pkg;

    // Register select values on cpu_addr
    localparam logic [1:0] ADDR_COUNT  = 2'd0;
    localparam logic [1:0] ADDR_DELTA  = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_THRESH = 2'd3;

    // STATUS read layout: level occupies [LVLW-1:0]; the flags sit directly
    // above it, so their positions are offsets from bit LVLW.
    localparam int STAT_IRQEN_OFS = 0;
    localparam int STAT_OVF_OFS   = 1;

    // STATUS write bits
    localparam int WR_IRQEN_BIT  = 0;
    localparam int WR_OVFCLR_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ACK,
        ST_PRE_WR,
        ST_PRE_SET,
        ST_PRE_ACK
    } ctrl_state_e;

endpackage

// File: rtl/rotary_delta_fifo.sv
// Small FIFO of signed count deltas. Pointers carry one extra wrap bit so
// that full and empty are distinguishable and level is a plain subtraction.
// A push together with a pop is accepted even when full: the head is read
// out on the same edge its slot is overwritten.
module rotary_delta_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer advance
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/rotary_event_ctrl.sv
// CPU-facing controller for the rotary encoder counter. Turns count changes
// into queued deltas, raises an interrupt on level threshold or overflow,
// and sequences count presets so the preset itself never appears as a delta.
module rotary_event_ctrl
    import rotary_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int LVLW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] enc_count,
    output logic             enc_en,
    output logic             enc_write,
    output logic [WIDTH-1:0] enc_writedata,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [1:0]       cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_ack,
    output logic             irq
);

    ctrl_state_e      state_q, state_d;
    logic [WIDTH-1:0] last_count_q, last_count_d;
    logic             primed_q, primed_d;
    logic             overflow_q, overflow_d;
    logic             irq_en_q, irq_en_d;
    logic [LVLW-1:0]  thresh_q, thresh_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             irq_q, irq_d;

    logic             is_idle, req_take, changed;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [WIDTH-1:0] fifo_dout, delta;
    logic [LVLW-1:0]  level;
    logic [WIDTH-1:0] rd_mux, status_w;

    assign is_idle  = (state_q == ST_IDLE);
    assign req_take = is_idle && cpu_req && !cpu_ack;
    assign delta    = enc_count - last_count_q;
    // Detection only runs in IDLE once the first sample has been taken;
    // other states leave last_count alone so a change is seen later.
    assign changed  = is_idle && primed_q && (enc_count != last_count_q);
    assign fifo_pop = req_take && !cpu_we && (cpu_addr == ADDR_DELTA) && !fifo_empty;
    assign fifo_push = changed && (!fifo_full || fifo_pop);

    rotary_delta_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (delta),
        .dout  (fifo_dout),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Encoder strobes and CPU handshake come straight off the state register
    // so an asynchronous reset drops them immediately.
    assign enc_en        = (state_q == ST_PRE_WR);
    assign enc_write     = (state_q == ST_PRE_WR);
    assign enc_writedata = wdata_q;
    assign cpu_ack       = (state_q == ST_RD_ACK) || (state_q == ST_PRE_ACK);
    assign cpu_rdata     = cpu_ack ? rdata_q : '0;
    assign irq           = irq_q;

    // Read data selection, sampled on the edge that accepts the request
    always_comb begin
        status_w = '0;
        status_w[LVLW-1:0]                = level;
        status_w[LVLW + STAT_IRQEN_OFS]   = irq_en_q;
        status_w[LVLW + STAT_OVF_OFS]     = overflow_q;
        rd_mux = '0;
        case (cpu_addr)
            ADDR_COUNT:  rd_mux = enc_count;
            ADDR_DELTA:  rd_mux = fifo_empty ? '0 : fifo_dout;
            ADDR_STATUS: rd_mux = status_w;
            default:     rd_mux = WIDTH'(thresh_q);
        endcase
    end

    // Sequencer next state plus register-write side effects
    always_comb begin
        state_d    = state_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        irq_en_d   = irq_en_q;
        thresh_d   = thresh_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (req_take) begin
                    if (cpu_we && (cpu_addr == ADDR_COUNT)) begin
                        state_d = ST_PRE_WR;
                        wdata_d = cpu_wdata;
                    end else begin
                        state_d = ST_RD_ACK;
                        rdata_d = cpu_we ? '0 : rd_mux;
                        if (cpu_we && (cpu_addr == ADDR_STATUS)) begin
                            irq_en_d = cpu_wdata[WR_IRQEN_BIT];
                            if (cpu_wdata[WR_OVFCLR_BIT]) overflow_d = 1'b0;
                        end
                        if (cpu_we && (cpu_addr == ADDR_THRESH))
                            thresh_d = cpu_wdata[LVLW-1:0];
                    end
                end
            end
            ST_RD_ACK:  state_d = ST_IDLE;
            ST_PRE_WR:  state_d = ST_PRE_SET;
            ST_PRE_SET: state_d = ST_PRE_ACK;
            ST_PRE_ACK: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        // A dropped delta wins over a same-cycle clear: the event is newer
        if (changed && fifo_full && !fifo_pop) overflow_d = 1'b1;
    end

    // Change tracking: prime on the first IDLE cycle, follow detected
    // changes, and resync to the preset value without generating an event
    always_comb begin
        last_count_d = last_count_q;
        primed_d     = primed_q;
        if (is_idle && !primed_q) begin
            last_count_d = enc_count;
            primed_d     = 1'b1;
        end else if (changed) begin
            last_count_d = enc_count;
        end else if (state_q == ST_PRE_SET) begin
            last_count_d = enc_count;
        end
    end

    // Interrupt condition, registered
    always_comb begin
        irq_d = irq_en_q &&
                (overflow_q || ((thresh_q != '0) && (level >= thresh_q)));
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_count_q <= '0;
            primed_q     <= 1'b0;
            overflow_q   <= 1'b0;
            irq_en_q     <= 1'b0;
            thresh_q     <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_count_q <= last_count_d;
            primed_q     <= primed_d;
            overflow_q   <= overflow_d;
            irq_en_q     <= irq_en_d;
            thresh_q     <= thresh_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            irq_q        <= irq_d;
        end
    end

endmodule

// File: doc/rotary_event_ctrl.md
Name: rotary_event_ctrl

Overview:
- Memory-mapped controller between the CPU bus and the rotary encoder counter block.
- Watches the encoder's 16-bit count and queues each change as a signed delta in a small FIFO.
- Raises an interrupt on a level threshold or on overflow.
- Sequences CPU-initiated count presets through the encoder's write/en interface so that a preset never produces a spurious delta.

Parameters:
- WIDTH, 16, width of the count, the deltas and the CPU data bus.
- DEPTH, 4, delta FIFO entries; must be a power of 2, at least 2.
- LVLW, 3, level field width; equals clog2(DEPTH)+1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enc_count  in  WIDTH  current count from the encoder block
- enc_en  out  1  encoder write enable, qualifier
- enc_write  out  1  encoder write strobe
- enc_writedata  out  WIDTH  preset value to the encoder
- cpu_req  in  1  transaction request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  2  register select
- cpu_wdata  in  WIDTH  write data
- cpu_rdata  out  WIDTH  read data; valid only while cpu_ack = 1
- cpu_ack  out  1  one-cycle completion pulse
- irq  out  1  registered interrupt

Behaviour:
- Reset (async, rst=1) clears every output to 0, plus all of the following:
  - FIFO empty; overflow=0; irq_en=0; thresh=0; FSM=IDLE; primed=0.
- Register map, by cpu_addr:
  - 0 COUNT: read returns enc_count. Write = preset request.
  - 1 DELTA: read pops the FIFO head (signed delta). Empty FIFO returns 0 and state is unchanged. Write is ignored but still acked.
  - 2 STATUS: read = {zeros, overflow, irq_en, level[LVLW-1:0]} (level in the low bits). Write: bit0 sets irq_en; bit1=1 clears overflow.
  - 3 THRESH: read/write the threshold; low LVLW bits are stored, the rest read as 0.
- Change detector, active only in IDLE:
  - Keeps last_count.
  - First cycle after reset: last_count <= enc_count, primed <= 1, no event.
  - Thereafter, when enc_count != last_count: push delta = enc_count - last_count (WIDTH-bit wrap, so 0x0000 after 0xFFFF gives +1), then last_count <= enc_count.
  - Push when full: the delta is dropped, overflow <= 1 (sticky), and last_count still updates.
  - Simultaneous push and pop: both take effect and level is unchanged. This includes the full case, which is not an overflow.
- FSM states: IDLE, RD_ACK, PRE_WR, PRE_SET, PRE_ACK.
  - IDLE, cpu_req=1, cpu_ack=0:
    - Write to addr 0 goes to PRE_WR and latches cpu_wdata into enc_writedata.
    - Any other request goes to RD_ACK; register writes and FIFO pops take effect on this edge.
  - RD_ACK: cpu_ack=1 with cpu_rdata for one cycle, then IDLE. Read latency is 1 cycle after req is sampled.
  - PRE_WR: enc_en=enc_write=1 for exactly one cycle, then PRE_SET.
  - PRE_SET: enc_count now equals the preset value; last_count <= enc_count; no event. Then PRE_ACK.
  - PRE_ACK: cpu_ack=1 for one cycle, then IDLE. Preset latency is 3 cycles.
  - Change detection is suppressed in PRE_WR and PRE_SET. Rotation steps during those two cycles are lost by design, because the encoder prioritises the write.
  - After ack, cpu_req must drop. A req still high in the cycle after ack starts a new transaction.
- irq, registered:
  - irq <= irq_en & (overflow | (thresh != 0 & level >= thresh)).
  - It deasserts one cycle after the condition clears, e.g. after a pop or an overflow clear.
- Reset asserted mid-preset aborts immediately: enc_en/enc_write go to 0 and no ack is issued.

Decomposition:
- Package rotary_ctrl_pkg holds:
  - Register address constants: ADDR_COUNT=0, ADDR_DELTA=1, ADDR_STATUS=2, ADDR_THRESH=3.
  - STATUS bit positions.
  - FSM state enum.
- One sub-module, rotary_delta_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports push, pop, din, dout, level, full, empty.
  - Async active-high reset.
  - Simultaneous push+pop is legal when full.

Test Plan:
- Reset, then enc_count steps 0→1→2→1 -> FIFO holds +1, +1, 0xFFFF; STATUS level=3; three DELTA reads return 0x0001, 0x0001, 0xFFFF, then a fourth read returns 0.
- enc_count 0xFFFF→0x0000 -> one delta 0x0001. Step 0x0000→0xFFFF -> delta 0xFFFF.
- Preset: write 0x0100 to addr 0 while enc_count=0x0005 -> enc_en=enc_write=1 for exactly 1 cycle with enc_writedata=0x0100; cpu_ack 3 cycles after req is sampled; no FIFO push; COUNT read returns 0x0100.
- Overflow: DEPTH=4, five steps with no reads -> level=4, overflow=1. STATUS write 0x0002 -> overflow=0. A step coinciding with a DELTA pop while full -> level stays 4 and overflow stays 0.
- IRQ: THRESH=2, STATUS write 0x0001 -> irq=0 after one step and irq=1 the cycle after the second push; one DELTA pop -> irq=0 the following cycle.
- Reset asserted during PRE_WR -> enc_en/enc_write drop immediately (async), no cpu_ack, all registers cleared.
